hack_alu: RTL and testbench

//  Hack-platform ALU datapath block, WIDTH bits wide.
//  - Computes one of the Hack functions of x and y from six control bits: zx, nx, zy, ny, f, no.
//  - Drives a combinational result with zero and negative flags, plus a registered copy for downstream pipeline stages.
//  - Sits in the CPU execute path between the D/A/M operand muxes and the register write-back.

---
 rtl/hack_alu.sv | 96 +++++++++
 tb/tb_hack_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu.sv
// hack_alu: Hack-platform ALU datapath with combinational result/flags and
// a registered copy for the next pipeline stage.
// Optional feature macro: HACK_ALU_EXT_FLAGS_EN adds carry (cy) and signed
// overflow (ov) flags plus their registered copies (cy_q, ov_q).
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] out_q,
  output logic             zr_q,
  output logic             ng_q
`ifdef HACK_ALU_EXT_FLAGS_EN
  ,
  output logic             cy,
  output logic             ov,
  output logic             cy_q,
  output logic             ov_q
`endif
);

  logic [WIDTH-1:0] xa, xb, ya, yb, sum, r;

`ifdef HACK_ALU_EXT_FLAGS_EN
  // The adder is one bit wider so the carry out of the MSB can be observed.
  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, xb} + {1'b0, yb};
  assign sum     = sum_ext[WIDTH-1:0];
`else
  // Carry out of the MSB is simply dropped, giving two's-complement wrap.
  assign sum = xb + yb;
`endif

  // Operand conditioning, function select and final negation.
  always_comb begin
    xa  = zx ? '0 : x;
    xb  = nx ? ~xa : xa;
    ya  = zy ? '0 : y;
    yb  = ny ? ~ya : ya;
    r   = f ? sum : (xb & yb);
    out = no ? ~r : r;
  end

  // Flags are taken from the final result, after the optional negation.
  always_comb begin
    zr = (out == '0);
    ng = out[WIDTH-1];
  end

`ifdef HACK_ALU_EXT_FLAGS_EN
  // Carry and overflow describe the adder itself, so they ignore no and
  // read as zero whenever the AND function is selected.
  always_comb begin
    cy = f & sum_ext[WIDTH];
    ov = f & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
  end
`endif

  // Output pipeline register; reset clears it immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
    end else begin
      out_q <= out;
      zr_q  <= zr;
      ng_q  <= ng;
    end
  end

`ifdef HACK_ALU_EXT_FLAGS_EN
  // Registered copies of the extended flags, cleared alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      cy_q <= cy;
      ov_q <= ov;
    end
  end
`endif

endmodule

// File: tb/tb_hack_alu.sv
// tb_hack_alu: self-checking bench for hack_alu (WIDTH = 16). Expected
// registered results are queued when stimulus is applied and popped one
// cycle later. Honours HACK_ALU_EXT_FLAGS_EN when defined.
module tb_hack_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out, out_q;
  logic        zr, ng, zr_q, ng_q;
`ifdef HACK_ALU_EXT_FLAGS_EN
  logic        cy, ov, cy_q, ov_q;
`endif

  typedef struct {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        cy;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  hack_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .zx    (zx),
    .nx    (nx),
    .zy    (zy),
    .ny    (ny),
    .f     (f),
    .no    (no),
    .out   (out),
    .zr    (zr),
    .ng    (ng),
    .out_q (out_q),
    .zr_q  (zr_q),
    .ng_q  (ng_q)
`ifdef HACK_ALU_EXT_FLAGS_EN
    ,
    .cy    (cy),
    .ov    (ov),
    .cy_q  (cy_q),
    .ov_q  (ov_q)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written in integer arithmetic, independent of the RTL form.
  function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv,
                                 input logic [5:0] ctl);
    exp_t e;
    int   ux, uy, sx, sy, us, ss;
    logic [15:0] a, b, r;
    a = ctl[5] ? 16'h0000 : xv;
    if (ctl[4]) a = 16'hFFFF - a;
    b = ctl[3] ? 16'h0000 : yv;
    if (ctl[2]) b = 16'hFFFF - b;
    ux = int'(a);
    uy = int'(b);
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    us = ux + uy;
    ss = sx + sy;
    if (ctl[1]) r = 16'(us % 65536);
    else        r = a & b;
    e.out = ctl[0] ? (16'hFFFF - r) : r;
    e.zr  = (e.out == 16'h0000);
    e.ng  = (e.out >= 16'h8000);
    e.cy  = ctl[1] && (us > 65535);
    e.ov  = ctl[1] && ((ss > 32767) || (ss < -32768));
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pushExpected();
    sb.push_back(model(x, y, {zx, nx, zy, ny, f, no}));
  endtask

  // Compare registered outputs with the entry queued one cycle earlier, then
  // the combinational outputs with the model, then queue the new expectation.
  task automatic checkOutput();
    exp_t e, p;
    if (sb.size() > 0) begin
      p = sb.pop_front();
      checkVal("out_q", out_q, p.out);
      checkVal("zr_q", {15'd0, zr_q}, {15'd0, p.zr});
      checkVal("ng_q", {15'd0, ng_q}, {15'd0, p.ng});
`ifdef HACK_ALU_EXT_FLAGS_EN
      checkVal("cy_q", {15'd0, cy_q}, {15'd0, p.cy});
      checkVal("ov_q", {15'd0, ov_q}, {15'd0, p.ov});
`endif
    end
    e = model(x, y, {zx, nx, zy, ny, f, no});
    checkVal("out", out, e.out);
    checkVal("zr", {15'd0, zr}, {15'd0, e.zr});
    checkVal("ng", {15'd0, ng}, {15'd0, e.ng});
`ifdef HACK_ALU_EXT_FLAGS_EN
    checkVal("cy", {15'd0, cy}, {15'd0, e.cy});
    checkVal("ov", {15'd0, ov}, {15'd0, e.ov});
`endif
    sb.push_back(e);
  endtask

  // Drive new inputs just after a rising edge, check at the following falling edge.
  task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv,
                               input logic [5:0] ctl);
    @(posedge clk);
    #1;
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = ctl;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic holdCycle();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkConst(input string tag, input logic [15:0] eo,
                            input logic ez, input logic en);
    checkVal({tag, ".out"}, out, eo);
    checkVal({tag, ".zr"}, {15'd0, zr}, {15'd0, ez});
    checkVal({tag, ".ng"}, {15'd0, ng}, {15'd0, en});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    x = 16'h0000;
    y = 16'h0000;
    {zx, nx, zy, ny, f, no} = 6'b000000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkVal("reset.out_q", out_q, 16'h0000);
    checkVal("reset.zr_q", {15'd0, zr_q}, 16'h0000);
    checkVal("reset.ng_q", {15'd0, ng_q}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h5678, 6'b101010);
    checkConst("zero", 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h1234, 16'h5678, 6'b111111);
    checkConst("one", 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h5678, 6'b111010);
    checkConst("minus1", 16'hFFFF, 1'b0, 1'b1);

    applyStimulus(16'h0011, 16'h0003, 6'b000010);
    checkConst("x+y", 16'h0014, 1'b0, 1'b0);
    applyStimulus(16'h0011, 16'h0003, 6'b010011);
    checkConst("x-y", 16'h000E, 1'b0, 1'b0);
    applyStimulus(16'h0011, 16'h0003, 6'b000111);
    checkConst("y-x", 16'hFFF2, 1'b0, 1'b1);
    applyStimulus(16'h0011, 16'h0003, 6'b001111);
    checkConst("-x", 16'hFFEF, 1'b0, 1'b1);

    applyStimulus(16'h00F0, 16'h0FF0, 6'b000000);
    checkConst("x&y", 16'h00F0, 1'b0, 1'b0);
    applyStimulus(16'h00F0, 16'h0FF0, 6'b010101);
    checkConst("x|y", 16'h0FF0, 1'b0, 1'b0);
    applyStimulus(16'h00F0, 16'h0FF0, 6'b001100);
    checkConst("x", 16'h00F0, 1'b0, 1'b0);

    applyStimulus(16'hFFFF, 16'h0001, 6'b000010);
    checkConst("wrap", 16'h0000, 1'b1, 1'b0);
`ifdef HACK_ALU_EXT_FLAGS_EN
    checkVal("wrap.cy", {15'd0, cy}, 16'h0001);
    checkVal("wrap.ov", {15'd0, ov}, 16'h0000);
`endif
    applyStimulus(16'h7FFF, 16'h0001, 6'b000010);
    checkConst("sovf", 16'h8000, 1'b0, 1'b1);
`ifdef HACK_ALU_EXT_FLAGS_EN
    checkVal("sovf.cy", {15'd0, cy}, 16'h0000);
    checkVal("sovf.ov", {15'd0, ov}, 16'h0001);
`endif

    applyStimulus(16'h0011, 16'h0003, 6'b000010);
    holdCycle();
    checkVal("reg.out_q", out_q, 16'h0014);
    #2 rst_n = 1'b0;
    #1;
    checkVal("arst.out_q", out_q, 16'h0000);
    checkVal("arst.zr_q", {15'd0, zr_q}, 16'h0000);
    checkVal("arst.ng_q", {15'd0, ng_q}, 16'h0000);
    checkVal("arst.out", out, 16'h0014);
    sb.delete();
    #1 rst_n = 1'b1;
    pushExpected();
    holdCycle();
    checkVal("release.out_q", out_q, 16'h0014);

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 6'($urandom_range(0, 63)));
    end
    holdCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
